// File: rtl/sys1_prgrom_bank.sv
// Banked program ROM for the System 1/2 Z80, with optional table decryption of the fixed region; loaded from the download stream.
// Latency: DTVALID two cycles after the RDREQ edge (three with decryption), plus one cycle per download write during READ/DEC.
// Backpressure: none; one extra request parks in a single slot (last wins), BUSY flags it, downloads stall the fetch.
module sys1_prgrom_bank #(
  parameter int          BANKS     = 4,
  parameter int          DECMODE   = 0,
  parameter logic [24:0] BANK_BASE = 25'h08000,
  parameter logic [24:0] TBL_BASE  = 25'h1E100,
  localparam int         BW        = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic          CLK48M,
  input  logic          RESETn,
  input  logic [15:0]   CPUAD,
  input  logic          CPUM1,
  input  logic          RDREQ,
  output logic [7:0]    DTOUT,
  output logic          DTVALID,
  output logic          BUSY,
  input  logic          BKWR,
  input  logic [7:0]    BKDT,
  output logic [BW-1:0] BANK,
  input  logic [24:0]   ROMAD,
  input  logic [7:0]    ROMDT,
  input  logic          ROMEN
);

  localparam logic [BW-1:0] BANK_MASK = BW'(BANKS - 1);
  localparam logic [25:0]   BANK_END  = {1'b0, BANK_BASE} + 26'(BANKS) * 26'h4000;
  localparam logic [25:0]   TBL_END   = {1'b0, TBL_BASE} + 26'd128;

  typedef enum logic [1:0] {IDLE, READ, DEC, OUT} state_t;

  typedef struct packed {
    logic [15:0]   addr;
    logic          m1;
    logic [BW-1:0] bank;
  } req_t;

  logic [7:0] fix_mem  [0:32767];
  logic [7:0] bank_mem [0:BANKS*16384-1];
  logic [7:0] tbl_mem  [0:127];

  state_t        state_q, state_d;
  req_t          cur_q, slot_q, in_req, cap_req;
  logic          slot_vld, cap_vld;
  logic          rd_en, tb_en, out_vld;
  logic [BW-1:0] bank_q;
  logic [7:0]    raw_dat, tbl_dat, dec_dat, out_dat;
  logic          f_bit;
  logic [6:0]    tbl_idx;
  logic [BW+13:0] bank_ridx, bank_widx;
  logic [6:0]    tbl_widx;
  logic          fix_wr_vld, bank_wr_vld, tbl_wr_vld;
  logic          bkdt_unused;

  assign in_req    = {CPUAD, CPUM1, bank_q};
  assign BANK      = bank_q;
  assign BUSY      = (state_q != IDLE) | slot_vld;
  assign bkdt_unused = ^BKDT[7:BW];

  // Download write decode; anything outside the three windows is dropped.
  assign fix_wr_vld  = ROMEN && (ROMAD < 25'h08000);
  assign bank_wr_vld = ROMEN && ({1'b0, ROMAD} >= {1'b0, BANK_BASE}) && ({1'b0, ROMAD} < BANK_END);
  assign tbl_wr_vld  = ROMEN && ({1'b0, ROMAD} >= {1'b0, TBL_BASE}) && ({1'b0, ROMAD} < TBL_END);
  assign bank_widx   = ROMAD[BW+13:0] - BANK_BASE[BW+13:0];
  assign tbl_widx    = ROMAD[6:0] - TBL_BASE[6:0];
  assign bank_ridx   = {cur_q.bank, cur_q.addr[13:0]};

  assign f_bit   = raw_dat[7];
  assign tbl_idx = {cur_q.addr[12], cur_q.addr[8], cur_q.addr[4], cur_q.addr[0],
                    cur_q.m1, raw_dat[5] ^ f_bit, raw_dat[3] ^ f_bit};
  assign dec_dat = (raw_dat & 8'h57) | (tbl_dat ^ {f_bit, 1'b0, f_bit, 1'b0, f_bit, 3'b000});
  assign out_dat = ((DECMODE != 0) && !cur_q.addr[15]) ? dec_dat : raw_dat;

  // Memory port: reads are only issued in cycles without a download write.
  always_ff @(posedge CLK48M) begin
    if (fix_wr_vld)  fix_mem[ROMAD[14:0]] <= ROMDT;
    if (bank_wr_vld) bank_mem[bank_widx]  <= ROMDT;
    if (tbl_wr_vld)  tbl_mem[tbl_widx]    <= ROMDT;
    if (rd_en) begin
      if (!cur_q.addr[15])      raw_dat <= fix_mem[cur_q.addr[14:0]];
      else if (!cur_q.addr[14]) raw_dat <= bank_mem[bank_ridx];
      else                      raw_dat <= 8'hFF;
    end
    if (tb_en) tbl_dat <= tbl_mem[tbl_idx];
  end

  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cap_vld = 1'b0;
    cap_req = in_req;
    rd_en   = 1'b0;
    tb_en   = 1'b0;
    out_vld = 1'b0;
    case (state_q)
      IDLE: begin
        if (RDREQ) begin
          state_d = READ;
          cap_vld = 1'b1;
        end
      end
      READ: begin
        if (!ROMEN) begin
          rd_en   = 1'b1;
          state_d = (DECMODE != 0) ? DEC : OUT;
        end
      end
      DEC: begin
        if (!ROMEN) begin
          tb_en   = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        out_vld = 1'b1;
        // A request arriving this very cycle overrides the parked one.
        if (RDREQ || slot_vld) begin
          state_d = READ;
          cap_vld = 1'b1;
          cap_req = RDREQ ? in_req : slot_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      cur_q    <= '0;
      slot_q   <= '0;
      slot_vld <= 1'b0;
      bank_q   <= '0;
      DTOUT    <= 8'hFF;
      DTVALID  <= 1'b0;
    end else begin
      if (cap_vld) cur_q <= cap_req;
      if (state_q == OUT) begin
        slot_vld <= 1'b0;
      end else if (RDREQ && (state_q != IDLE)) begin
        slot_vld <= 1'b1;
        slot_q   <= in_req;
      end
      if (BKWR) bank_q <= BKDT[BW-1:0] & BANK_MASK;
      DTVALID <= out_vld;
      if (out_vld) DTOUT <= out_dat;
    end
  end

endmodule

// File: tb/tb_sys1_prgrom_bank.sv
// Bench for sys1_prgrom_bank: plain and decrypting instances share all inputs and are checked against a byte-array model.
module tb_sys1_prgrom_bank;

  logic        CLK48M = 1'b0;
  logic        RESETn;
  logic [15:0] CPUAD;
  logic        CPUM1, RDREQ, BKWR, ROMEN;
  logic [7:0]  BKDT, ROMDT;
  logic [24:0] ROMAD;
  logic [7:0]  DTOUT0, DTOUT1;
  logic        DTVALID0, DTVALID1, BUSY0, BUSY1;
  logic [1:0]  BANK0, BANK1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_fix [32768];
  logic [7:0] m_bnk [4][16384];
  logic [7:0] m_tbl [128];
  int         m_bank = 0;

  always #5 CLK48M = ~CLK48M;

  sys1_prgrom_bank #(.BANKS(4), .DECMODE(0)) u_dut0 (
    .CLK48M(CLK48M), .RESETn(RESETn), .CPUAD(CPUAD), .CPUM1(CPUM1), .RDREQ(RDREQ),
    .DTOUT(DTOUT0), .DTVALID(DTVALID0), .BUSY(BUSY0), .BKWR(BKWR), .BKDT(BKDT),
    .BANK(BANK0), .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN));

  sys1_prgrom_bank #(.BANKS(4), .DECMODE(1)) u_dut1 (
    .CLK48M(CLK48M), .RESETn(RESETn), .CPUAD(CPUAD), .CPUM1(CPUM1), .RDREQ(RDREQ),
    .DTOUT(DTOUT1), .DTVALID(DTVALID1), .BUSY(BUSY1), .BKWR(BKWR), .BKDT(BKDT),
    .BANK(BANK1), .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_wr(input int a, input logic [7:0] d);
    if (a < 'h8000)                           m_fix[a] = d;
    else if (a >= 'h8000 && a < 'h18000)      m_bnk[(a - 'h8000) / 'h4000][(a - 'h8000) % 'h4000] = d;
    else if (a >= 'h1E100 && a < 'h1E180)     m_tbl[a - 'h1E100] = d;
  endfunction

  function automatic logic [7:0] model_rd(input int a, input bit m1, input int bk, input bit dec);
    logic [7:0] d;
    bit f;
    int idx;
    if (a >= 'hC000) return 8'hFF;
    if (a >= 'h8000) return m_bnk[bk][a - 'h8000];
    d = m_fix[a];
    if (!dec) return d;
    f   = d[7];
    idx = ((a >> 12) & 1) * 64 + ((a >> 8) & 1) * 32 + ((a >> 4) & 1) * 16 + (a & 1) * 8
        + int'(m1) * 4 + int'(d[5] ^ f) * 2 + int'(d[3] ^ f);
    return (d & 8'h57) | (m_tbl[idx] ^ (f ? 8'hA8 : 8'h00));
  endfunction

  task automatic dl(input int a, input logic [7:0] d);
    ROMAD = 25'(a); ROMDT = d; ROMEN = 1'b1;
    @(posedge CLK48M); #1 ROMEN = 1'b0;
    model_wr(a, d);
  endtask

  task automatic setbank(input logic [7:0] v);
    BKDT = v; BKWR = 1'b1;
    @(posedge CLK48M); #1 BKWR = 1'b0;
    m_bank = int'(v & 8'h03);
  endtask

  // bkat: -1 no bank write, 0 with the request, k>0 at edge k of the fetch.
  task automatic fetch(input string nm, input int a, input bit m1, input logic [7:0] e0,
                       input logic [7:0] e1, input int bkat, input logic [7:0] bkv);
    int l0 = 0, l1 = 0, c0 = 0, c1 = 0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    CPUAD = 16'(a); CPUM1 = m1; RDREQ = 1'b1; BKDT = bkv; BKWR = (bkat == 0);
    @(posedge CLK48M); #1 RDREQ = 1'b0; BKWR = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      BKWR = (bkat == k);
      @(posedge CLK48M); #1 BKWR = 1'b0;
      if (DTVALID0) begin c0++; if (l0 == 0) l0 = k; d0 = DTOUT0; end
      if (DTVALID1) begin c1++; if (l1 == 0) l1 = k; d1 = DTOUT1; end
    end
    if (bkat >= 0) m_bank = int'(bkv & 8'h03);
    chk({nm, "_lat0"}, l0, 2);
    chk({nm, "_lat1"}, l1, 3);
    chk({nm, "_cnt0"}, c0, 1);
    chk({nm, "_cnt1"}, c1, 1);
    chk({nm, "_dat0"}, d0, e0);
    chk({nm, "_dat1"}, d1, e1);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        m1;
    logic        wr;
    logic [7:0]  bkdt;
    logic [1:0]  bank;
    logic [7:0]  d;
    logic [6:0]  tidx;
    logic [7:0]  tval;
    logic [7:0]  exp0;
    logic [7:0]  exp1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int p0 [$];
    int p1 [$];
    logic [7:0] v0 [$];
    logic [7:0] v1 [$];
    int bm0, bm1, nv;
    logic [7:0] xa, xb, xc, xd;

    vecs[0] = '{16'h1234, 1'b0, 1'b1, 8'h00, 2'd0, 8'h3C, 7'h53, 8'h11, 8'h3C, 8'h15};
    vecs[1] = '{16'h0000, 1'b1, 1'b1, 8'h00, 2'd0, 8'h80, 7'h07, 8'h20, 8'h80, 8'h88};
    vecs[2] = '{16'h8010, 1'b0, 1'b1, 8'h06, 2'd2, 8'hA5, 7'h00, 8'h00, 8'hA5, 8'hA5};
    vecs[3] = '{16'h8000, 1'b0, 1'b1, 8'hF0, 2'd0, 8'h80, 7'h00, 8'h00, 8'h80, 8'h80};
    vecs[4] = '{16'hC000, 1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 7'h00, 8'h00, 8'hFF, 8'hFF};
    vecs[5] = '{16'h7FFF, 1'b0, 1'b1, 8'h00, 2'd0, 8'hFF, 7'h78, 8'h5A, 8'hFF, 8'hF7};
    vecs[6] = '{16'hBFFF, 1'b0, 1'b1, 8'h07, 2'd3, 8'h42, 7'h00, 8'h00, 8'h42, 8'h42};
    vecs[7] = '{16'h0100, 1'b1, 1'b1, 8'h00, 2'd0, 8'h28, 7'h27, 8'hC3, 8'h28, 8'hC3};

    RESETn = 1'b0; CPUAD = '0; CPUM1 = 1'b0; RDREQ = 1'b0; BKWR = 1'b0; BKDT = '0;
    ROMAD = '0; ROMDT = '0; ROMEN = 1'b0;
    repeat (3) @(posedge CLK48M);
    #1;
    chk("rst_dtout0", DTOUT0, 8'hFF);   chk("rst_dtout1", DTOUT1, 8'hFF);
    chk("rst_valid0", DTVALID0, 0);     chk("rst_valid1", DTVALID1, 0);
    chk("rst_busy0", BUSY0, 0);         chk("rst_busy1", BUSY1, 0);
    chk("rst_bank0", BANK0, 0);         chk("rst_bank1", BANK1, 0);
    RESETn = 1'b1;
    @(posedge CLK48M); #1;

    // Directed vectors with hand-computed results.
    for (int i = 0; i < 8; i++) begin
      setbank(vecs[i].bkdt);
      chk($sformatf("row%0d_bank0", i), BANK0, vecs[i].bank);
      chk($sformatf("row%0d_bank1", i), BANK1, vecs[i].bank);
      if (vecs[i].wr) begin
        if (vecs[i].addr < 16'h8000) dl(int'(vecs[i].addr), vecs[i].d);
        else dl('h8000 + int'(vecs[i].bank) * 'h4000 + int'(vecs[i].addr) - 'h8000, vecs[i].d);
        dl('h1E100 + int'(vecs[i].tidx), vecs[i].tval);
      end
      fetch($sformatf("row%0d", i), int'(vecs[i].addr), vecs[i].m1, vecs[i].exp0, vecs[i].exp1, -1, 8'h00);
    end

    for (int i = 0; i < 128; i++) dl('h1E100 + i, 8'($urandom));

    // Bank write alongside the request uses the old bank; a write mid-fetch is ignored by that fetch.
    setbank(8'h06);
    fetch("bk_coinc", 'h8010, 1'b0, 8'hA5, 8'hA5, 0, 8'h01);
    chk("bk_coinc_bank", BANK0, 1);
    dl('hC010, 8'h77);
    fetch("bk_during", 'h8010, 1'b0, 8'h77, 8'h77, 1, 8'h02);
    chk("bk_during_bank", BANK1, 2);

    // Three back-to-back requests: second is overwritten by third.
    xa = model_rd('h1234, 1'b0, m_bank, 1'b0); xb = model_rd('h0100, 1'b1, m_bank, 1'b0);
    xc = model_rd('h1234, 1'b0, m_bank, 1'b1); xd = model_rd('h0100, 1'b1, m_bank, 1'b1);
    bm0 = 0; bm1 = 0;
    CPUAD = 16'h1234; CPUM1 = 1'b0; RDREQ = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge CLK48M); #1;
      if (k == 0) CPUAD = 16'hC000;
      if (k == 1) begin CPUAD = 16'h0100; CPUM1 = 1'b1; end
      if (k == 2) RDREQ = 1'b0;
      if (DTVALID0) begin p0.push_back(k); v0.push_back(DTOUT0); end
      if (DTVALID1) begin p1.push_back(k); v1.push_back(DTOUT1); end
      if (BUSY0 !== (k <= 3)) bm0++;
      if (BUSY1 !== (k <= 5)) bm1++;
    end
    chk("b2b_cnt0", p0.size(), 2);
    chk("b2b_cnt1", p1.size(), 2);
    chk("b2b_busy0", bm0, 0);
    chk("b2b_busy1", bm1, 0);
    if (p0.size() == 2) begin
      chk("b2b_t0a", p0[0], 2); chk("b2b_t0b", p0[1], 4);
      chk("b2b_d0a", v0[0], xa); chk("b2b_d0b", v0[1], xb);
    end
    if (p1.size() == 2) begin
      chk("b2b_t1a", p1[0], 3); chk("b2b_t1b", p1[1], 6);
      chk("b2b_d1a", v1[0], xc); chk("b2b_d1b", v1[1], xd);
    end

    // Two download cycles while READ is pending delay both instances by two.
    xa = model_rd('h1234, 1'b0, m_bank, 1'b0); xc = model_rd('h1234, 1'b0, m_bank, 1'b1);
    p0.delete(); p1.delete(); v0.delete(); v1.delete();
    CPUAD = 16'h1234; CPUM1 = 1'b0; RDREQ = 1'b1;
    @(posedge CLK48M); #1 RDREQ = 1'b0; ROMAD = 25'h05000; ROMDT = 8'h99; ROMEN = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK48M); #1;
      if (k == 2) begin ROMEN = 1'b0; model_wr('h5000, 8'h99); end
      if (DTVALID0) begin p0.push_back(k); v0.push_back(DTOUT0); end
      if (DTVALID1) begin p1.push_back(k); v1.push_back(DTOUT1); end
    end
    chk("romen_cnt0", p0.size(), 1);
    chk("romen_cnt1", p1.size(), 1);
    if (p0.size() == 1) begin chk("romen_lat0", p0[0], 4); chk("romen_dat0", v0[0], xa); end
    if (p1.size() == 1) begin chk("romen_lat1", p1[0], 5); chk("romen_dat1", v1[0], xc); end
    fetch("romen_wr", 'h5000, 1'b0, model_rd('h5000, 1'b0, m_bank, 1'b0),
          model_rd('h5000, 1'b1 & 1'b0, m_bank, 1'b1), -1, 8'h00);

    // Reset while the decrypting instance sits in DEC.
    setbank(8'h03);
    CPUAD = 16'h1234; CPUM1 = 1'b0; RDREQ = 1'b1;
    @(posedge CLK48M); #1 RDREQ = 1'b0;
    @(posedge CLK48M); #2 RESETn = 1'b0;
    #1;
    chk("mrst_dtout0", DTOUT0, 8'hFF); chk("mrst_dtout1", DTOUT1, 8'hFF);
    chk("mrst_busy0", BUSY0, 0);       chk("mrst_busy1", BUSY1, 0);
    chk("mrst_bank0", BANK0, 0);       chk("mrst_bank1", BANK1, 0);
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK48M); #1;
      if (k == 2) RESETn = 1'b1;
      if (DTVALID0 || DTVALID1) nv++;
    end
    m_bank = 0;
    chk("mrst_novalid", nv, 0);
    chk("mrst_idle", {BUSY0, BUSY1}, 0);

    // Writes just past the bank and table windows must be dropped.
    dl('h18000, 8'h11);
    dl('h1E180, 8'h11);
    fetch("drop", 'h8000, 1'b0, model_rd('h8000, 1'b0, 0, 1'b0), model_rd('h8000, 1'b0, 0, 1'b1), -1, 8'h00);

    // Randomised fetches against the model.
    for (int it = 0; it < 40; it++) begin
      int r, a;
      bit m1;
      logic [7:0] d;
      r  = $urandom_range(0, 9);
      m1 = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (r < 5) begin
        a = $urandom_range(0, 'h7FFF);
        dl(a, d);
      end else if (r < 9) begin
        if ($urandom_range(0, 1) == 1) setbank(8'($urandom_range(0, 255)));
        a = 'h8000 + $urandom_range(0, 'h3FFF);
        dl('h8000 + m_bank * 'h4000 + a - 'h8000, d);
      end else begin
        a = 'hC000 + $urandom_range(0, 'h3FFF);
      end
      fetch($sformatf("rand%0d", it), a, m1, model_rd(a, m1, m_bank, 1'b0),
            model_rd(a, m1, m_bank, 1'b1), -1, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
